// File: rtl/lod_chunk_scan_ctrl.sv
// Sequential leading-one scanner: walks a wide operand one slice at a time
// from the top slice down through a single shared leading-one detector, then
// reports the global index of the leading one, a zero flag, and the operand
// left-normalized so the leading one lands on the MSB.

// Combinational leading-one detector for one slice.
module lod_chunk_scan_lod #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0]         vec,
  output logic                     nz,
  output logic [$clog2(WIDTH)-1:0] idx
);
  localparam int unsigned IW = $clog2(WIDTH);

  // Priority encode: the highest set bit visited last wins.
  always_comb begin
    nz  = |vec;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec[i]) idx = IW'(i);
    end
  end
endmodule

module lod_chunk_scan_ctrl #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned CHUNK_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DATA_WIDTH)-1:0] out_pos,
  output logic                          out_zero,
  output logic [DATA_WIDTH-1:0]         out_norm
);
  localparam int unsigned NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned PW     = $clog2(DATA_WIDTH);
  localparam int unsigned CW     = $clog2(CHUNK_WIDTH);
  localparam int unsigned KW     = $clog2(NCHUNK);
  localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);
  localparam logic [PW-1:0] P_TOP = PW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    SHIFT,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [KW-1:0]          k;
  logic [PW-1:0]          pos_q;
  logic [CHUNK_WIDTH-1:0] slice;
  logic                   slice_nz;
  logic [CW-1:0]          slice_idx;
  logic [PW-1:0]          shamt;
  logic                   accept;

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign shamt     = P_TOP - pos_q;

  // Select the slice currently presented to the shared detector.
  always_comb begin
    slice = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (k == KW'(i)) slice = data_q[i*CHUNK_WIDTH +: CHUNK_WIDTH];
    end
  end

  lod_chunk_scan_lod #(
    .WIDTH (CHUNK_WIDTH)
  ) u_lod (
    .vec (slice),
    .nz  (slice_nz),
    .idx (slice_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SCAN;
      SCAN: begin
        if (slice_nz)       state_n = SHIFT;
        else if (k == '0)   state_n = DONE;
      end
      SHIFT:   state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  // Datapath: operand capture, slice walk, leading-one position and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      k        <= K_TOP;
      pos_q    <= '0;
      out_pos  <= '0;
      out_zero <= 1'b0;
      out_norm <= '0;
    end else if (flush) begin
      k <= K_TOP;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q <= in_data;
            k      <= K_TOP;
          end
        end
        SCAN: begin
          if (slice_nz) begin
            // Slice width is a power of two, so k*CHUNK_WIDTH + idx is a concat.
            pos_q <= {k, slice_idx};
          end else if (k != '0) begin
            k <= k - KW'(1);
          end else begin
            out_zero <= 1'b1;
            out_pos  <= '0;
            out_norm <= '0;
          end
        end
        SHIFT: begin
          out_norm <= data_q << shamt;
          out_pos  <= pos_q;
          out_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
